exe_stage: RTL and testbench

//  Execute stage of the 5-stage MIPS pipeline, directly downstream of decode: consumes ds_to_es_bus, runs ALU and HI/LO ops, issues data-SRAM requests, produces es_to_ms_bus.

---
 rtl/exe_stage_pkg.sv | 72 +++++++
 rtl/exe_stage_div_iter.sv | 74 +++++++
 rtl/exe_stage.sv | 97 +++++++++
 tb/tb_exe_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_stage_pkg.sv
// exe_stage_pkg: bus layouts, widths and ALU opcode indices shared by the execute stage.
package exe_stage_pkg;
    localparam int DS_TO_ES_BUS_WD     = 178;
    localparam int ES_TO_MS_BUS_WD     = 139;
    localparam int SPECIAL_REG_ADDR_WD = 2;
    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_SLT   = 2;
    localparam int ALU_SLTU  = 3;
    localparam int ALU_AND   = 4;
    localparam int ALU_NOR   = 5;
    localparam int ALU_OR    = 6;
    localparam int ALU_XOR   = 7;
    localparam int ALU_SLL   = 8;
    localparam int ALU_SRL   = 9;
    localparam int ALU_SRA   = 10;
    localparam int ALU_LUI   = 11;
    localparam int ALU_MULT  = 12;
    localparam int ALU_MULTU = 13;
    localparam int ALU_DIV   = 14;
    localparam int ALU_DIVU  = 15;

    typedef struct packed {
        logic        md_op;
        logic        mt_op;
        logic [31:0] special_value;
        logic        mf_op;
        logic [SPECIAL_REG_ADDR_WD-1:0] dest_special;
        logic        src2_zext;
        logic [15:0] alu_op;
        logic        load_op;
        logic        src1_sa;
        logic        src1_pc;
        logic        src2_sext;
        logic        src2_8;
        logic        gr_we;
        logic        mem_we;
        logic [4:0]  dest;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] pc;
    } ds_bus_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [SPECIAL_REG_ADDR_WD-1:0] dest_special;
        logic        mt_op;
        logic        md_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_bus_t;

    // Shifts take the amount from src1 and the value from src2.
    function automatic logic [31:0] alu_calc(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d, sra_r;
        logic [32:0] du;
        logic slt;
        d     = a - b;
        du    = {1'b0, a} - {1'b0, b};
        slt   = (a[31] & ~b[31]) | (~(a[31] ^ b[31]) & d[31]);
        sra_r = $signed(b) >>> a[4:0];
        return ({32{op[0]}} & (a + b)) | ({32{op[1]}} & d) | {31'b0, op[2] & slt} | {31'b0, op[3] & du[32]}
             | ({32{op[4]}} & (a & b)) | ({32{op[5]}} & ~(a | b)) | ({32{op[6]}} & (a | b)) | ({32{op[7]}} & (a ^ b))
             | ({32{op[8]}} & (b << a[4:0])) | ({32{op[9]}} & (b >> a[4:0])) | ({32{op[10]}} & sra_r)
             | ({32{op[11]}} & {b[15:0], 16'b0});
    endfunction
endpackage

// File: rtl/exe_stage_div_iter.sv
// exe_stage_div_iter: iterative restoring divider (IDLE/BUSY/DONE), BITS quotient bits per cycle.
module exe_stage_div_iter #(
    parameter int BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic        ack_i,
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] q_o,
    output logic [31:0] r_o
);
    localparam int N = 32 / BITS;
    localparam logic [5:0] LAST = 6'(N - 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] a_q, r_q, y_q, a_d, r_d;
    logic        neg_q_q, neg_r_q, ge;
    logic [32:0] sh, sub;
    always_comb begin
        a_d = a_q;
        r_d = r_q;
        sh  = '0;
        sub = '0;
        ge  = 1'b0;
        for (int i = 0; i < BITS; i++) begin
            sh  = {r_d, a_d[31]};
            sub = sh - {1'b0, y_q};
            ge  = sh >= {1'b0, y_q};
            a_d = {a_d[30:0], ge};
            r_d = ge ? sub[31:0] : sh[31:0];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            r_q     <= '0;
            y_q     <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= BUSY;
                    cnt_q   <= '0;
                    a_q     <= (signed_i & x_i[31]) ? -x_i : x_i;
                    y_q     <= (signed_i & y_i[31]) ? -y_i : y_i;
                    r_q     <= '0;
                    neg_q_q <= signed_i & (x_i[31] ^ y_i[31]);
                    neg_r_q <= signed_i & x_i[31];
                end
                BUSY: begin
                    a_q     <= a_d;
                    r_q     <= r_d;
                    cnt_q   <= cnt_q + 6'd1;
                    state_q <= (cnt_q == LAST) ? DONE : BUSY;
                end
                DONE: if (ack_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy_o = state_q == BUSY;
    assign done_o = state_q == DONE;
    assign q_o    = neg_q_q ? -a_q : a_q;
    assign r_o    = neg_r_q ? -r_q : r_q;
endmodule

// File: rtl/exe_stage.sv
// exe_stage: MIPS execute stage (ALU, HI/LO, data-SRAM request, forwarding).
// ES_DIV_STALL_CNT_EN adds a saturating divide-stall cycle counter output.
module exe_stage import exe_stage_pkg::*; #(
    parameter int DIV_BITS_PER_CYC = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_wen,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata,
    output logic [4:0]                 es_real_dest,
    output logic [31:0]                exe_forward_data,
    output logic                       es_res_from_mem,
    output logic [31:0]                exe_forward_data_HI,
    output logic [31:0]                exe_forward_data_LO,
    output logic                       es_mt_op,
    output logic                       es_mult_multu_div_divu_op,
    output logic [1:0]                 es_dest_special
`ifdef ES_DIV_STALL_CNT_EN
    ,output logic [31:0]               es_div_stall_cnt
`endif
);
    ds_bus_t     b_q;
    logic        es_valid_q, es_ready_go, div_op, mul_op, div_busy, div_done;
    logic [31:0] src1, src2, alu_res, result, div_q, div_r, hi, lo;
    logic [63:0] mul;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            b_q        <= '0;
        end else begin
            if (es_allowin) es_valid_q <= ds_to_es_valid;
            if (ds_to_es_valid & es_allowin) b_q <= ds_to_es_bus;
        end
    end
    assign div_op      = b_q.alu_op[ALU_DIV] | b_q.alu_op[ALU_DIVU];
    assign mul_op      = b_q.alu_op[ALU_MULT] | b_q.alu_op[ALU_MULTU];
    assign es_ready_go = !div_op | div_done;
    assign es_allowin  = !es_valid_q | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid_q & es_ready_go;

    exe_stage_div_iter #(.BITS(DIV_BITS_PER_CYC)) u_div (
        .clk     (clk),
        .rst     (reset),
        .start_i (es_valid_q & div_op & !div_busy & !div_done),
        .signed_i(b_q.alu_op[ALU_DIV]),
        .ack_i   (es_to_ms_valid & ms_allowin),
        .x_i     (b_q.rs),
        .y_i     (b_q.rt),
        .busy_o  (div_busy),
        .done_o  (div_done),
        .q_o     (div_q),
        .r_o     (div_r)
    );

    assign src1    = b_q.src1_sa ? {27'b0, b_q.imm[10:6]} : b_q.src1_pc ? b_q.pc : b_q.rs;
    assign src2    = b_q.src2_8 ? 32'd8 : b_q.src2_sext ? {{16{b_q.imm[15]}}, b_q.imm}
                   : b_q.src2_zext ? {16'b0, b_q.imm} : b_q.rt;
    assign alu_res = alu_calc(b_q.alu_op[11:0], src1, src2);
    assign result  = b_q.mf_op ? b_q.special_value : alu_res;
    // Sign-extending to 64 bits makes the low 64 bits of the product correct for mult.
    assign mul = {{32{b_q.alu_op[ALU_MULT] & b_q.rs[31]}}, b_q.rs} * {{32{b_q.alu_op[ALU_MULT] & b_q.rt[31]}}, b_q.rt};
    assign hi  = mul_op ? mul[63:32] : div_op ? div_r : b_q.mt_op ? b_q.rs : 32'b0;
    assign lo  = mul_op ? mul[31:0]  : div_op ? div_q : b_q.mt_op ? b_q.rs : 32'b0;

    assign es_to_ms_bus = {hi, lo, b_q.dest_special, b_q.mt_op, b_q.md_op, b_q.load_op, b_q.gr_we,
                           b_q.dest, result, b_q.pc};
    assign data_sram_en    = es_valid_q & ms_allowin & (b_q.load_op | b_q.mem_we) & es_ready_go;
    assign data_sram_wen   = {4{data_sram_en & b_q.mem_we}};
    assign data_sram_addr  = alu_res;
    assign data_sram_wdata = b_q.rt;

    assign es_real_dest        = (es_valid_q & b_q.gr_we) ? b_q.dest : 5'd0;
    assign exe_forward_data    = result;
    assign es_res_from_mem     = es_valid_q & b_q.load_op;
    assign exe_forward_data_HI = hi;
    assign exe_forward_data_LO = lo;
    assign es_mt_op            = es_valid_q & b_q.mt_op;
    assign es_mult_multu_div_divu_op = es_valid_q & b_q.md_op;
    assign es_dest_special     = es_valid_q ? b_q.dest_special : 2'b0;

`ifdef ES_DIV_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else if (es_valid_q & div_op & !es_ready_go & ~&stall_cnt_q) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
    assign es_div_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed self-checking bench for exe_stage.
module tb_exe_stage;
    import exe_stage_pkg::*;
    localparam int DIV_N = 32;
    logic clk = 1'b0;
    logic reset, ms_allowin, es_allowin, ds_to_es_valid, es_to_ms_valid;
    ds_bus_t bus_in;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    es_bus_t ms;
    logic data_sram_en, es_res_from_mem, es_mt_op, es_md;
    logic [3:0] data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata, fwd, fwd_hi, fwd_lo;
    logic [4:0] es_real_dest;
    logic [1:0] es_dest_special;
    int n_tests = 0;
    int n_fail = 0;

    exe_stage dut (
        .clk(clk), .reset(reset), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
        .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(bus_in),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .es_real_dest(es_real_dest), .exe_forward_data(fwd), .es_res_from_mem(es_res_from_mem),
        .exe_forward_data_HI(fwd_hi), .exe_forward_data_LO(fwd_lo), .es_mt_op(es_mt_op),
        .es_mult_multu_div_divu_op(es_md), .es_dest_special(es_dest_special)
    );

    assign ms = es_to_ms_bus;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic ds_bus_t mk(input int idx, input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [15:0] imm, input logic [4:0] dest);
        ds_bus_t b;
        b = '0;
        b.alu_op[idx] = 1'b1;
        b.rs = rs;
        b.rt = rt;
        b.imm = imm;
        b.dest = dest;
        b.gr_we = 1'b1;
        b.pc = 32'hBFC0_0100;
        return b;
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for a single cycle; returns 1 ns after it is latched.
    task automatic issue(input ds_bus_t b);
        bus_in = b;
        ds_to_es_valid = 1'b1;
        next_cyc();
        ds_to_es_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ms_allowin = 1'b1;
        ds_to_es_valid = 1'b0;
        bus_in = '0;
        repeat (3) next_cyc();
        n_tests++; if (es_to_ms_valid !== 1'b0) begin n_fail++; $display("FAIL reset es_to_ms_valid: got %b expected 0", es_to_ms_valid); end
        n_tests++; if (es_allowin !== 1'b1) begin n_fail++; $display("FAIL reset es_allowin: got %b expected 1", es_allowin); end
        n_tests++; if (es_real_dest !== 5'd0) begin n_fail++; $display("FAIL reset es_real_dest: got %h expected 0", es_real_dest); end
        n_tests++; if (data_sram_en !== 1'b0) begin n_fail++; $display("FAIL reset data_sram_en: got %b expected 0", data_sram_en); end
        n_tests++; if ({es_md, es_mt_op, es_res_from_mem, es_dest_special} !== 5'b0) begin n_fail++; $display("FAIL reset flags: got %b expected 0", {es_md, es_mt_op, es_res_from_mem, es_dest_special}); end
        reset = 1'b0;
        next_cyc();
    endtask

    task automatic test_addu();
        issue(mk(ALU_ADD, 32'd5, 32'd7, 16'd0, 5'd9));
        n_tests++; if (fwd !== 32'd12) begin n_fail++; $display("FAIL addu result: got %h expected 0000000c", fwd); end
        n_tests++; if (ms.result !== 32'd12) begin n_fail++; $display("FAIL addu bus result: got %h expected 0000000c", ms.result); end
        n_tests++; if (es_real_dest !== 5'd9) begin n_fail++; $display("FAIL addu es_real_dest: got %0d expected 9", es_real_dest); end
        n_tests++; if (es_to_ms_valid !== 1'b1) begin n_fail++; $display("FAIL addu no-stall: got %b expected 1", es_to_ms_valid); end
        next_cyc();
        n_tests++; if ({es_to_ms_valid, es_real_dest} !== 6'b0) begin n_fail++; $display("FAIL addu drain: got %b expected 0", {es_to_ms_valid, es_real_dest}); end
    endtask

    typedef struct {
        int          idx;
        logic [31:0] rs, rt;
        logic [15:0] imm;
        logic        sa, zx, sx;
        logic [31:0] exp;
    } alu_vec_t;

    task automatic test_alu();
        alu_vec_t v[12];
        ds_bus_t b;
        v = '{
            '{ALU_SUB,  32'd10,        32'd3,         16'h0000, 1'b0, 1'b0, 1'b0, 32'd7},
            '{ALU_SLT,  32'hFFFFFFFF,  32'd1,         16'h0000, 1'b0, 1'b0, 1'b0, 32'd1},
            '{ALU_SLTU, 32'hFFFFFFFF,  32'd1,         16'h0000, 1'b0, 1'b0, 1'b0, 32'd0},
            '{ALU_AND,  32'h0000F0F0,  32'h0000FF00,  16'h0000, 1'b0, 1'b0, 1'b0, 32'h0000F000},
            '{ALU_NOR,  32'h0,         32'h0,         16'h0000, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF},
            '{ALU_OR,   32'h0F,        32'hF0,        16'h0000, 1'b0, 1'b0, 1'b0, 32'hFF},
            '{ALU_XOR,  32'hFF,        32'h0F,        16'h0000, 1'b0, 1'b0, 1'b0, 32'hF0},
            '{ALU_SLL,  32'h0,         32'd1,         16'h0100, 1'b1, 1'b0, 1'b0, 32'd16},
            '{ALU_SRL,  32'h0,         32'h80000000,  16'h0100, 1'b1, 1'b0, 1'b0, 32'h08000000},
            '{ALU_SRA,  32'h0,         32'h80000000,  16'h0100, 1'b1, 1'b0, 1'b0, 32'hF8000000},
            '{ALU_LUI,  32'h0,         32'h0,         16'h1234, 1'b0, 1'b1, 1'b0, 32'h12340000},
            '{ALU_ADD,  32'd10,        32'h0,         16'hFFFF, 1'b0, 1'b0, 1'b1, 32'd9}
        };
        for (int i = 0; i < 12; i++) begin
            b = mk(v[i].idx, v[i].rs, v[i].rt, v[i].imm, 5'd3);
            b.src1_sa = v[i].sa;
            b.src2_zext = v[i].zx;
            b.src2_sext = v[i].sx;
            issue(b);
            n_tests++; if (fwd !== v[i].exp) begin n_fail++; $display("FAIL alu vec %0d: got %h expected %h", i, fwd, v[i].exp); end
        end
        next_cyc();
    endtask

    task automatic test_lw();
        ds_bus_t b;
        b = mk(ALU_ADD, 32'h1000, 32'h0, 16'hFFFC, 5'd4);
        b.load_op = 1'b1;
        b.src2_sext = 1'b1;
        issue(b);
        n_tests++; if (data_sram_en !== 1'b1) begin n_fail++; $display("FAIL lw en: got %b expected 1", data_sram_en); end
        n_tests++; if (data_sram_wen !== 4'h0) begin n_fail++; $display("FAIL lw wen: got %h expected 0", data_sram_wen); end
        n_tests++; if (data_sram_addr !== 32'h0FFC) begin n_fail++; $display("FAIL lw addr: got %h expected 00000ffc", data_sram_addr); end
        n_tests++; if ({es_res_from_mem, ms.res_from_mem} !== 2'b11) begin n_fail++; $display("FAIL lw res_from_mem: got %b expected 11", {es_res_from_mem, ms.res_from_mem}); end
        next_cyc();
        n_tests++; if ({es_res_from_mem, data_sram_en} !== 2'b00) begin n_fail++; $display("FAIL lw one cycle: got %b expected 00", {es_res_from_mem, data_sram_en}); end
    endtask

    task automatic test_sw_backpressure();
        ds_bus_t b;
        b = mk(ALU_ADD, 32'h2000, 32'hDEADBEEF, 16'h0008, 5'd0);
        b.gr_we = 1'b0;
        b.mem_we = 1'b1;
        b.src2_sext = 1'b1;
        ms_allowin = 1'b0;
        issue(b);
        n_tests++; if ({data_sram_en, es_allowin} !== 2'b00) begin n_fail++; $display("FAIL sw blocked en/allowin: got %b expected 00", {data_sram_en, es_allowin}); end
        ms_allowin = 1'b1;
        #1;
        n_tests++; if ({data_sram_en, data_sram_wen} !== 5'b11111) begin n_fail++; $display("FAIL sw en/wen: got %b expected 11111", {data_sram_en, data_sram_wen}); end
        n_tests++; if ({data_sram_addr, data_sram_wdata} !== {32'h2008, 32'hDEADBEEF}) begin n_fail++; $display("FAIL sw addr/wdata: got %h expected 00002008deadbeef", {data_sram_addr, data_sram_wdata}); end
        n_tests++; if (es_real_dest !== 5'd0) begin n_fail++; $display("FAIL sw real_dest: got %0d expected 0", es_real_dest); end
        next_cyc();
    endtask

    task automatic test_mult();
        ds_bus_t b;
        b = mk(ALU_MULT, 32'hFFFFFFFF, 32'd2, 16'h0, 5'd0);
        b.gr_we = 1'b0;
        b.md_op = 1'b1;
        b.dest_special = 2'b11;
        issue(b);
        n_tests++; if ({fwd_hi, fwd_lo} !== {32'hFFFFFFFF, 32'hFFFFFFFE}) begin n_fail++; $display("FAIL mult hi/lo: got %h expected fffffffffffffffe", {fwd_hi, fwd_lo}); end
        n_tests++; if ({es_to_ms_valid, es_md, es_dest_special} !== 4'b1111) begin n_fail++; $display("FAIL mult flags: got %b expected 1111", {es_to_ms_valid, es_md, es_dest_special}); end
        b.alu_op = '0;
        b.alu_op[ALU_MULTU] = 1'b1;
        issue(b);
        n_tests++; if ({ms.hi, ms.lo} !== {32'h1, 32'hFFFFFFFE}) begin n_fail++; $display("FAIL multu hi/lo: got %h expected 00000001fffffffe", {ms.hi, ms.lo}); end
        n_tests++; if (es_to_ms_valid !== 1'b1) begin n_fail++; $display("FAIL multu single cycle: got %b expected 1", es_to_ms_valid); end
        next_cyc();
    endtask

    task automatic test_div_op(input string name, input logic sgn, input logic [31:0] x, input logic [31:0] y,
                               input logic [31:0] eq, input logic [31:0] er);
        ds_bus_t b;
        int k;
        b = mk(sgn ? ALU_DIV : ALU_DIVU, x, y, 16'h0, 5'd0);
        b.gr_we = 1'b0;
        b.md_op = 1'b1;
        b.dest_special = 2'b11;
        issue(b);
        n_tests++; if ({es_to_ms_valid, es_allowin, es_md} !== 3'b001) begin n_fail++; $display("FAIL %s entry stall: got %b expected 001", name, {es_to_ms_valid, es_allowin, es_md}); end
        k = 0;
        while (!es_to_ms_valid && k < 200) begin next_cyc(); k++; end
        n_tests++; if (k !== DIV_N + 1) begin n_fail++; $display("FAIL %s latency: got %0d expected %0d", name, k, DIV_N + 1); end
        n_tests++; if ({ms.lo, ms.hi} !== {eq, er}) begin n_fail++; $display("FAIL %s q/r: got %h expected %h", name, {ms.lo, ms.hi}, {eq, er}); end
        next_cyc();
    endtask

    task automatic test_div_hold();
        ds_bus_t b;
        int k;
        b = mk(ALU_DIVU, 32'h1234, 32'h0, 16'h0, 5'd0);
        b.gr_we = 1'b0;
        b.md_op = 1'b1;
        ms_allowin = 1'b0;
        issue(b);
        k = 0;
        while (!es_to_ms_valid && k < 200) begin next_cyc(); k++; end
        n_tests++; if (k !== DIV_N + 1) begin n_fail++; $display("FAIL divu0 latency: got %0d expected %0d", k, DIV_N + 1); end
        for (int i = 0; i < 5; i++) begin
            n_tests++; if ({fwd_lo, fwd_hi, es_allowin, es_to_ms_valid} !== {32'hFFFFFFFF, 32'h1234, 1'b0, 1'b1}) begin n_fail++; $display("FAIL divu0 hold %0d: got %h/%h allowin %b valid %b expected ffffffff/00001234 0 1", i, fwd_lo, fwd_hi, es_allowin, es_to_ms_valid); end
            next_cyc();
        end
        ms_allowin = 1'b1;
        #1;
        n_tests++; if (es_allowin !== 1'b1) begin n_fail++; $display("FAIL divu0 release allowin: got %b expected 1", es_allowin); end
        next_cyc();
        n_tests++; if (es_to_ms_valid !== 1'b0) begin n_fail++; $display("FAIL divu0 drained: got %b expected 0", es_to_ms_valid); end
    endtask

    task automatic test_div_reset();
        ds_bus_t b;
        b = mk(ALU_DIVU, 32'd100, 32'd7, 16'h0, 5'd0);
        b.gr_we = 1'b0;
        b.md_op = 1'b1;
        issue(b);
        repeat (10) next_cyc();
        #2 reset = 1'b1;
        #1;
        n_tests++; if ({es_to_ms_valid, es_md, es_allowin} !== 3'b001) begin n_fail++; $display("FAIL async reset mid-divide: got %b expected 001", {es_to_ms_valid, es_md, es_allowin}); end
        next_cyc();
        reset = 1'b0;
        next_cyc();
        test_div_op("divu after reset", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    endtask

    task automatic test_mt_mf();
        ds_bus_t b;
        b = mk(ALU_ADD, 32'hABCD0123, 32'h0, 16'h0, 5'd0);
        b.gr_we = 1'b0;
        b.mt_op = 1'b1;
        b.dest_special = 2'b01;
        issue(b);
        n_tests++; if ({es_mt_op, es_md, es_dest_special} !== 4'b1001) begin n_fail++; $display("FAIL mthi flags: got %b expected 1001", {es_mt_op, es_md, es_dest_special}); end
        n_tests++; if (fwd_hi !== 32'hABCD0123) begin n_fail++; $display("FAIL mthi hi: got %h expected abcd0123", fwd_hi); end
        b.dest_special = 2'b10;
        issue(b);
        n_tests++; if ({fwd_lo, es_dest_special} !== {32'hABCD0123, 2'b10}) begin n_fail++; $display("FAIL mtlo: got %h expected abcd01232", {fwd_lo, es_dest_special}); end
        b = mk(ALU_ADD, 32'd1, 32'd1, 16'h0, 5'd8);
        b.mf_op = 1'b1;
        b.special_value = 32'hCAFEBABE;
        issue(b);
        n_tests++; if ({fwd, es_real_dest, es_mt_op} !== {32'hCAFEBABE, 5'd8, 1'b0}) begin n_fail++; $display("FAIL mfhi result: got %h expected cafebabe/8/0", {fwd, es_real_dest, es_mt_op}); end
        next_cyc();
    endtask

    initial begin
        test_reset();
        test_addu();
        test_alu();
        test_lw();
        test_sw_backpressure();
        test_mult();
        test_div_op("div -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        test_div_op("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        test_div_op("div 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
        test_div_op("div min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        test_div_op("div -5/0", 1'b1, 32'hFFFFFFFB, 32'd0, 32'd1, 32'hFFFFFFFB);
        test_div_hold();
        test_div_reset();
        test_mt_mf();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
